// File: rtl/cnn_frame_ctrl_if.sv
// Bus bundle for cnn_frame_ctrl: frame control, parameter load, pixel and pipeline handshakes,
// parameter register outputs, frame counters and debug state.
interface cnn_frame_ctrl_if;
    logic               start;
    logic               busy;
    logic               done;
    logic [31:0]        param_data;
    logic               param_valid;
    logic               param_ready;
    logic signed [15:0] pix_data;
    logic               pix_valid;
    logic               pix_ready;
    logic signed [15:0] pipe_pixel;
    logic               pipe_valid;
    logic               pipe_ready;
    logic [3:0]         pipe_valid_out;
    logic signed [15:0] weight_b1 [0:3][0:8];
    logic signed [31:0] bias_b1   [0:3];
    logic signed [15:0] weight_b2 [0:3][0:3][0:8];
    logic signed [31:0] bias_b2   [0:3];
    logic [15:0]        in_cnt;
    logic [15:0]        out_cnt;
    logic [2:0]         dbg_state;
    logic               params_loaded;

    // Environment side: issues frames, parameters and pixels, reports pipeline outputs.
    modport master (
        output start, param_data, param_valid, pix_data, pix_valid, pipe_ready, pipe_valid_out,
        input  busy, done, param_ready, pix_ready, pipe_pixel, pipe_valid,
               weight_b1, bias_b1, weight_b2, bias_b2, in_cnt, out_cnt, dbg_state, params_loaded
    );

    // Controller side.
    modport slave (
        input  start, param_data, param_valid, pix_data, pix_valid, pipe_ready, pipe_valid_out,
        output busy, done, param_ready, pix_ready, pipe_pixel, pipe_valid,
               weight_b1, bias_b1, weight_b2, bias_b2, in_cnt, out_cnt, dbg_state, params_loaded
    );
endinterface

// File: rtl/cnn_frame_ctrl.sv
// Frame controller for a two-layer 3x3 CNN: loads 188 parameter words, streams pixels, counts outputs.
// Optional macro CNN_CTRL_PARAM_REUSE_EN lets a start skip LOAD once parameters are resident.
module cnn_frame_ctrl #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int OUT_PIX = (IMG_W - 4) * (IMG_H - 4)
) (
    input  logic            clk,
    input  logic            reset,
    cnn_frame_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0]  LAST_WORD = 8'd187;
    localparam logic [15:0] IN_TOTAL  = 16'(IMG_W * IMG_H);
    localparam logic [15:0] OUT_TOTAL = 16'(OUT_PIX);

    logic [2:0]  state_q, state_d;
    logic [7:0]  param_idx_q, param_idx_d;
    logic [15:0] in_cnt_q, in_cnt_d;
    logic [15:0] out_cnt_q, out_cnt_d;
    logic        params_loaded_q, params_loaded_d;

    logic signed [15:0] w1_q [0:3][0:8];
    logic signed [31:0] b1_q [0:3];
    logic signed [15:0] w2_q [0:3][0:3][0:8];
    logic signed [31:0] b2_q [0:3];

    logic load_xfer;
    logic pix_xfer;
    logic out_pulse;
    logic unused_pvo;

    // Handshakes: a word moves on a cycle where its valid and ready are both high;
    // valid never waits on ready, and pixel ready is the pipeline's ready passed straight through.
    assign load_xfer  = (state_q == S_LOAD) && bus.param_valid;
    assign pix_xfer   = (state_q == S_STREAM) && bus.pix_valid && bus.pipe_ready;
    assign out_pulse  = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && bus.pipe_valid_out[0];
    assign unused_pvo = ^bus.pipe_valid_out[3:1];

    always_comb begin
        state_d         = state_q;
        param_idx_d     = param_idx_q;
        params_loaded_d = params_loaded_q;
        in_cnt_d        = in_cnt_q;
        out_cnt_d       = out_cnt_q;
        if (pix_xfer) in_cnt_d = in_cnt_q + 16'd1;
        if (out_pulse && (out_cnt_q < OUT_TOTAL)) out_cnt_d = out_cnt_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    in_cnt_d    = 16'd0;
                    out_cnt_d   = 16'd0;
                    param_idx_d = 8'd0;
`ifdef CNN_CTRL_PARAM_REUSE_EN
                    state_d = params_loaded_q ? S_STREAM : S_LOAD;
`else
                    state_d = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                if (load_xfer) begin
                    param_idx_d = param_idx_q + 8'd1;
                    if (param_idx_q == LAST_WORD) begin
                        state_d         = S_STREAM;
                        params_loaded_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                // Output count can complete before the input count; DRAIN then exits at once.
                if ((pix_xfer && (in_cnt_q == IN_TOTAL - 16'd1)) || (out_cnt_d == OUT_TOTAL))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_cnt_d == OUT_TOTAL) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            param_idx_q     <= 8'd0;
            in_cnt_q        <= 16'd0;
            out_cnt_q       <= 16'd0;
            params_loaded_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            param_idx_q     <= param_idx_d;
            in_cnt_q        <= in_cnt_d;
            out_cnt_q       <= out_cnt_d;
            params_loaded_q <= params_loaded_d;
        end
    end

    // Word order: w1[k][t] (0..35), b1[k] (36..39), w2[o][i][t] (40..183), b2[k] (184..187).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                b1_q[k] <= '0;
                b2_q[k] <= '0;
                for (int t = 0; t < 9; t++) begin
                    w1_q[k][t] <= '0;
                    for (int i = 0; i < 4; i++) w2_q[k][i][t] <= '0;
                end
            end
        end else if (load_xfer) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(param_idx_q) == 36 + k)  b1_q[k] <= bus.param_data;
                if (int'(param_idx_q) == 184 + k) b2_q[k] <= bus.param_data;
                for (int t = 0; t < 9; t++) begin
                    if (int'(param_idx_q) == k * 9 + t) w1_q[k][t] <= bus.param_data[15:0];
                    for (int i = 0; i < 4; i++)
                        if (int'(param_idx_q) == 40 + k * 36 + i * 9 + t)
                            w2_q[k][i][t] <= bus.param_data[15:0];
                end
            end
        end
    end

    assign bus.busy          = (state_q == S_LOAD) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign bus.done          = (state_q == S_DONE);
    assign bus.param_ready   = (state_q == S_LOAD);
    assign bus.pipe_pixel    = bus.pix_data;
    assign bus.pipe_valid    = (state_q == S_STREAM) && bus.pix_valid;
    assign bus.pix_ready     = (state_q == S_STREAM) && bus.pipe_ready;
    assign bus.weight_b1     = w1_q;
    assign bus.bias_b1       = b1_q;
    assign bus.weight_b2     = w2_q;
    assign bus.bias_b2       = b2_q;
    assign bus.in_cnt        = in_cnt_q;
    assign bus.out_cnt       = out_cnt_q;
    assign bus.dbg_state     = state_q;
    assign bus.params_loaded = params_loaded_q;
endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Bench for cnn_frame_ctrl (6x6 frame, 4 outputs): directed frames, scoreboard queues for
// pipeline pixels and done pulses, direct checks on parameter registers and FSM state.
module tb_cnn_frame_ctrl;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    logic [15:0] exp_q[$];
    logic [31:0] exp_done_q[$];

    cnn_frame_ctrl_if bus();

    cnn_frame_ctrl #(.IMG_W(6), .IMG_H(6), .OUT_PIX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic load_words(input logic [31:0] base);
        for (int i = 0; i < 188; i++) begin
            if (i == 50) begin
                bus.param_valid = 1'b0;
                bus.param_data  = 32'hDEAD_BEEF;
                tick();
                chk("param_ready_stall", 32'(bus.param_ready), 32'd1);
            end
            bus.param_data  = base + 32'(i) + 32'd1;
            bus.param_valid = 1'b1;
            tick();
            if (i == 0) chk("w1_first_word", 32'($unsigned(bus.weight_b1[0][0])), 32'(16'(base + 32'd1)));
        end
        bus.param_valid = 1'b0;
    endtask

    task automatic check_params(input logic [31:0] base);
        chk("w1_0_0",   32'($unsigned(bus.weight_b1[0][0])),    32'(16'(base + 32'd1)));
        chk("w1_3_8",   32'($unsigned(bus.weight_b1[3][8])),    32'(16'(base + 32'd36)));
        chk("b1_0",     bus.bias_b1[0],                          base + 32'd37);
        chk("b1_3",     bus.bias_b1[3],                          base + 32'd40);
        chk("w2_0_0_0", 32'($unsigned(bus.weight_b2[0][0][0])), 32'(16'(base + 32'd41)));
        chk("w2_1_2_3", 32'($unsigned(bus.weight_b2[1][2][3])), 32'(16'(base + 32'd98)));
        chk("w2_3_3_8", 32'($unsigned(bus.weight_b2[3][3][8])), 32'(16'(base + 32'd184)));
        chk("b2_0",     bus.bias_b2[0],                          base + 32'd185);
        chk("b2_3",     bus.bias_b2[3],                          base + 32'd188);
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.pipe_valid && bus.pipe_ready) begin
                if (exp_q.size() == 0) chk("pipe_unexpected", 32'(bus.pipe_pixel), 32'hFFFF_FFFF);
                else chk("pipe_pixel", 32'($unsigned(bus.pipe_pixel)), 32'(exp_q.pop_front()));
            end
            if (bus.done) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", 32'(bus.done), 32'd0);
                else chk("done_counts", {bus.in_cnt, bus.out_cnt}, exp_done_q.pop_front());
            end
        end
    end

    initial begin
        int cnt;
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.param_data     = '0;
        bus.param_valid    = 1'b0;
        bus.pix_data       = '0;
        bus.pix_valid      = 1'b1;
        bus.pipe_ready     = 1'b1;
        bus.pipe_valid_out = '0;
        tick();
        tick();
        chk("rst_state",       32'(bus.dbg_state),     32'(S_IDLE));
        chk("rst_busy",        32'(bus.busy),          32'd0);
        chk("rst_done",        32'(bus.done),          32'd0);
        chk("rst_param_ready", 32'(bus.param_ready),   32'd0);
        chk("rst_pix_ready",   32'(bus.pix_ready),     32'd0);
        chk("rst_pipe_valid",  32'(bus.pipe_valid),    32'd0);
        chk("rst_counts",      {bus.in_cnt, bus.out_cnt}, 32'd0);
        chk("rst_loaded",      32'(bus.params_loaded), 32'd0);
        chk("rst_b2_3",        bus.bias_b2[3],         32'd0);
        bus.pix_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Frame 1: load value=index, 36 pixels, 2 outputs during STREAM and 2 in DRAIN.
        start_frame();
        chk("f1_state_load",  32'(bus.dbg_state),   32'(S_LOAD));
        chk("f1_param_ready", 32'(bus.param_ready), 32'd1);
        chk("f1_busy",        32'(bus.busy),        32'd1);
        load_words(32'd0);
        chk("f1_state_stream", 32'(bus.dbg_state),     32'(S_STREAM));
        chk("f1_loaded",       32'(bus.params_loaded), 32'd1);
        check_params(32'd0);
        for (int i = 0; i < 36; i++) begin
            bus.pix_data  = 16'(i * 7 - 100);
            bus.pix_valid = 1'b1;
            bus.pipe_valid_out = (i == 10 || i == 20) ? 4'b0001 : ((i == 5) ? 4'b1110 : 4'b0000);
            exp_q.push_back(bus.pix_data);
            #1;
            chk("f1_pix_ready", 32'(bus.pix_ready), 32'd1);
            tick();
        end
        bus.pix_valid = 1'b0;
        bus.pipe_valid_out = '0;
        chk("f1_state_drain", 32'(bus.dbg_state),          32'(S_DRAIN));
        chk("f1_counts_drain", {bus.in_cnt, bus.out_cnt}, {16'd36, 16'd2});
        exp_done_q.push_back({16'd36, 16'd4});
        bus.pipe_valid_out = 4'b0001;
        tick();
        bus.pipe_valid_out = 4'b0000;
        tick();
        chk("f1_drain_hold", 32'(bus.dbg_state), 32'(S_DRAIN));
        bus.pipe_valid_out = 4'b0001;
        tick();
        bus.pipe_valid_out = 4'b0000;
        chk("f1_state_done", 32'(bus.dbg_state), 32'(S_DONE));
        chk("f1_done",       32'(bus.done),      32'd1);
        chk("f1_busy_done",  32'(bus.busy),      32'd0);
        tick();
        chk("f1_idle",       32'(bus.dbg_state), 32'(S_IDLE));
        chk("f1_done_pulse", 32'(bus.done),      32'd0);
        // Pixels offered in IDLE are not accepted.
        bus.pix_valid = 1'b1;
        bus.pix_data  = 16'sd5;
        #1;
        chk("idle_pix_ready", 32'(bus.pix_ready), 32'd0);
        tick();
        bus.pix_valid = 1'b0;
        chk("idle_in_cnt", 32'(bus.in_cnt), 32'd36);
        check_params(32'd0);

        // Frame 2: reuse or reload, then toggled ready, then reset after 20 pixels.
        start_frame();
`ifdef CNN_CTRL_PARAM_REUSE_EN
        chk("f2_state_stream", 32'(bus.dbg_state),   32'(S_STREAM));
        chk("f2_param_ready",  32'(bus.param_ready), 32'd0);
        check_params(32'd0);
`else
        chk("f2_state_load", 32'(bus.dbg_state), 32'(S_LOAD));
        load_words(32'h0001_FF00);
        chk("f2_state_stream", 32'(bus.dbg_state), 32'(S_STREAM));
        check_params(32'h0001_FF00);
`endif
        chk("f2_counts_clear", {bus.in_cnt, bus.out_cnt}, 32'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            bus.pipe_ready = (c % 2 == 1);
            bus.pix_valid  = 1'b1;
            bus.pix_data   = 16'(1000 + cnt);
            if (bus.pipe_ready) exp_q.push_back(bus.pix_data);
            #1;
            chk("f2_pix_ready", 32'(bus.pix_ready), 32'(bus.pipe_ready));
            tick();
            if (c % 2 == 1) cnt++;
            chk("f2_in_cnt", 32'(bus.in_cnt), 32'(cnt));
        end
        bus.pix_valid  = 1'b0;
        bus.pipe_ready = 1'b1;
        chk("f2_still_stream", 32'(bus.dbg_state), 32'(S_STREAM));
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        chk("f2_rst_state",  32'(bus.dbg_state),     32'(S_IDLE));
        chk("f2_rst_counts", {bus.in_cnt, bus.out_cnt}, 32'd0);
        chk("f2_rst_loaded", 32'(bus.params_loaded), 32'd0);
        chk("f2_rst_busy",   32'(bus.busy),          32'd0);
        chk("f2_rst_w1",     32'($unsigned(bus.weight_b1[0][0])), 32'd0);
        chk("f2_rst_b2",     bus.bias_b2[3],         32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("f2_idle_after", 32'(bus.dbg_state), 32'(S_IDLE));

        // Frame 3: reload after reset, outputs complete before inputs.
        start_frame();
        chk("f3_state_load", 32'(bus.dbg_state), 32'(S_LOAD));
        load_words(32'd0);
        check_params(32'd0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 16'sh7FFF;
        bus.pipe_valid_out = 4'b0001;
        exp_q.push_back(bus.pix_data);
        tick();
        bus.pix_valid = 1'b0;
        chk("f3_both_counts", {bus.in_cnt, bus.out_cnt}, {16'd1, 16'd1});
        tick();
        tick();
        chk("f3_pre_drain", 32'(bus.dbg_state), 32'(S_STREAM));
        exp_done_q.push_back({16'd1, 16'd4});
        tick();
        chk("f3_state_drain", 32'(bus.dbg_state), 32'(S_DRAIN));
        chk("f3_out_cnt",     32'(bus.out_cnt),   32'd4);
        tick();
        bus.pipe_valid_out = 4'b0000;
        chk("f3_state_done", 32'(bus.dbg_state), 32'(S_DONE));
        chk("f3_saturate",   32'(bus.out_cnt),   32'd4);
        tick();
        chk("f3_idle", 32'(bus.dbg_state), 32'(S_IDLE));
        tick();

        // final report
        chk("pixel_queue_empty", 32'(exp_q.size()),      32'd0);
        chk("done_queue_empty",  32'(exp_done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cnn_frame_ctrl.md
CNN_FRAME_CTRL -- requirements
Module: cnn_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28: input frame width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28: input frame height in pixels.
REQ-003 SHALL have parameter OUT_PIX, default (IMG_W-4)*(IMG_H-4): conv outputs per frame after two 3x3 valid layers.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 SHALL have: reset  in  1  synchronous, active-high.
REQ-006 SHALL have: start  in  1  frame request; busy  out  1; done  out  1  one-cycle pulse.
REQ-007 SHALL have: param_data  in  32  parameter word; param_valid  in  1; param_ready  out  1.
REQ-008 SHALL have: pix_data  in  signed 16; pix_valid  in  1; pix_ready  out  1  (pixel source side).
REQ-009 SHALL have: pipe_pixel  out  signed 16; pipe_valid  out  1; pipe_ready  in  1; pipe_valid_out  in  4  (conv pipeline side).
REQ-010 SHALL have: weight_b1  out  signed 16 [0:3][0:8]; bias_b1  out  signed 32 [0:3]; weight_b2  out  signed 16 [0:3][0:3][0:8]; bias_b2  out  signed 32 [0:3].
REQ-011 SHALL have: in_cnt  out  16  pixels accepted this frame; out_cnt  out  16  outputs counted this frame.

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE; busy=1 in LOAD, STREAM, DRAIN.
REQ-013 IDLE: start=1 SHALL go to LOAD next cycle, clearing in_cnt, out_cnt, param index; start outside IDLE SHALL be ignored.
REQ-014 LOAD: param_ready=1; word transfers on param_valid&&param_ready; 188 words in fixed order: 36 weight_b1 (row-major [k][t], bits 15:0), 4 bias_b1, 144 weight_b2 (row-major [o][i][t], bits 15:0), 4 bias_b2.
REQ-015 Transferred word SHALL appear on its output register the cycle after transfer; after word 188 FSM SHALL enter STREAM next cycle and set params_loaded.
REQ-016 STREAM: pipe_pixel=pix_data, pipe_valid=pix_valid, pix_ready=pipe_ready, all combinational (zero latency); outside STREAM pipe_valid=0, pix_ready=0.
REQ-017 Pixel transfer on pix_valid&&pipe_ready in STREAM SHALL increment in_cnt; on the transfer making in_cnt=IMG_W*IMG_H, FSM SHALL enter DRAIN next cycle.
REQ-018 out_cnt SHALL increment on each cycle pipe_valid_out[0]=1 while in STREAM or DRAIN; ignored in other states; saturates at OUT_PIX.
REQ-019 DRAIN: when out_cnt reaches OUT_PIX, FSM SHALL enter DONE; also from STREAM if out_cnt reaches OUT_PIX first, DRAIN is entered and exits immediately the following cycle.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; parameter registers SHALL hold values until next LOAD or reset.
REQ-021 Simultaneous pixel transfer and pipe_valid_out[0] in one cycle SHALL update both counters.

Reset
REQ-022 reset SHALL, on the clock edge it is sampled high, force IDLE, busy=0, done=0, param_ready=0, pix_ready=0, pipe_valid=0, in_cnt=0, out_cnt=0, params_loaded=0, all weight/bias registers=0.
REQ-023 reset mid-LOAD/STREAM/DRAIN SHALL abort the frame with no done pulse; reset SHALL dominate start.

Configuration
REQ-024 Macro CNN_CTRL_PARAM_REUSE_EN: when defined, start in IDLE with params_loaded=1 SHALL go directly to STREAM, skipping LOAD and keeping registers; start with params_loaded=0 SHALL still go to LOAD.
REQ-025 Without CNN_CTRL_PARAM_REUSE_EN, every start SHALL pass through LOAD (188 words).

Verification
REQ-026 reset, start, 188 words value=index -> weight_b1[0][0]=1, bias_b1[0]=37, weight_b2[0][0][0]=41, bias_b2[3]=188; STREAM entered cycle after word 188.
REQ-027 IMG_W=IMG_H=6, OUT_PIX=4, pipe_ready always 1, 36 pixels, 4 pipe_valid_out[0] pulses -> in_cnt=36, out_cnt=4, one done pulse, busy falls with it.
REQ-028 pipe_ready toggled 1/0 each cycle, pix_valid=1 -> in_cnt increments only on ready cycles; pix_ready tracks pipe_ready combinationally.
REQ-029 reset asserted after 20 pixels in STREAM -> IDLE next cycle, counters and registers 0, no done; next start reloads parameters.
REQ-030 with CNN_CTRL_PARAM_REUSE_EN, second start after completed frame -> STREAM one cycle after start, param_ready never 1, weights unchanged; without macro -> LOAD again.
